// File: rtl/dff_e_pkg.sv
// Shared definitions for the enabled register pipeline: occupancy width helper
// and the data reset value.
package dff_e_pkg;

    localparam logic DATA_RST_BIT = 1'b0;

    function automatic int occ_width(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dff_e_stage.sv
// One enabled pipeline stage: WIDTH data bits plus a valid bit.
// Priority at the clock edge is rst, then flush, then E; otherwise hold.
module dff_e_stage
    import dff_e_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             E,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q     <= {WIDTH{DATA_RST_BIT}};
            q_vld <= 1'b0;
        end else if (E) begin
            q     <= d;
            q_vld <= d_vld;
        end
    end

endmodule

// File: rtl/dff_e_pipe.sv
// Stallable DEPTH-stage register pipeline with valid tracking.
// Define DFF_E_PIPE_OCC_EN to add the registered occupancy counter port occ.
module dff_e_pipe
    import dff_e_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E,
    input  logic             flush,
    input  logic [WIDTH-1:0] D,
    input  logic             D_vld,
    output logic [WIDTH-1:0] Q,
    output logic             Q_vld
`ifdef DFF_E_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occ
`endif
);

    // Index 0 is the pipeline input; index k+1 is the output of stage k.
    logic [DEPTH:0][WIDTH-1:0] data_s;
    logic [DEPTH:0]            vld_s;

    assign data_s[0] = D;
    assign vld_s[0]  = D_vld;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        dff_e_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .E     (E),
            .d     (data_s[k]),
            .d_vld (vld_s[k]),
            .q     (data_s[k+1]),
            .q_vld (vld_s[k+1])
        );
    end

    assign Q     = data_s[DEPTH];
    assign Q_vld = vld_s[DEPTH];

`ifdef DFF_E_PIPE_OCC_EN
    localparam int OCC_W = occ_width(DEPTH);

    // Tracks the valid count incrementally: one word in, one word out per advance.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ <= '0;
        end else if (E) begin
            occ <= occ + OCC_W'(D_vld) - OCC_W'(vld_s[DEPTH]);
        end
    end

    occ_in_range: assert property (@(posedge clk) occ <= OCC_W'(DEPTH));
`endif

endmodule

// File: tb/tb_dff_e_pipe.sv
// Directed and random checks of dff_e_pipe against hand values and a queue model.
module tb_dff_e_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int OCC_W = dff_e_pkg::occ_width(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             E;
    logic             flush;
    logic [WIDTH-1:0] D;
    logic             D_vld;
    logic [WIDTH-1:0] Q;
    logic             Q_vld;
`ifdef DFF_E_PIPE_OCC_EN
    logic [OCC_W-1:0] occ;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
    } word_t;

    word_t m_q[$];

    always #5 clk = ~clk;

    dff_e_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .E     (E),
        .flush (flush),
        .D     (D),
        .D_vld (D_vld),
        .Q     (Q),
        .Q_vld (Q_vld)
`ifdef DFF_E_PIPE_OCC_EN
        ,
        .occ   (occ)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_occ();
        int c = 0;
        foreach (m_q[i]) c += int'(m_q[i].v);
        return c;
    endfunction

    task automatic model_clear();
        m_q.delete();
        for (int i = 0; i < DEPTH; i++) m_q.push_back('0);
    endtask

    // Applies the current inputs at the next rising edge, updates the model,
    // then samples the DUT 1 time unit later.
    task automatic tick();
        word_t w;
        @(posedge clk);
        if (rst || flush) begin
            model_clear();
        end else if (E) begin
            w.v = D_vld;
            w.d = D;
            m_q.push_front(w);
            void'(m_q.pop_back());
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".Q"}, 32'(Q), 32'(m_q[DEPTH-1].d));
        chk({tag, ".Q_vld"}, 32'(Q_vld), 32'(m_q[DEPTH-1].v));
`ifdef DFF_E_PIPE_OCC_EN
        chk({tag, ".occ"}, 32'(occ), 32'(model_occ()));
`endif
    endtask

    task automatic drive(input logic e, input logic [WIDTH-1:0] d, input logic v);
        E     = e;
        D     = d;
        D_vld = v;
    endtask

    initial begin
        int occ_exp[8];
        occ_exp = '{4, 3, 3, 2, 2, 2, 2, 2};
        model_clear();
        rst = 1'b1;
        flush = 1'b0;
        drive(1'b1, 8'hFF, 1'b1);

        // Reset with active inputs: outputs stay cleared.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_Q", 32'(Q), 32'h0);
            chk("rst_Q_vld", 32'(Q_vld), 32'h0);
`ifdef DFF_E_PIPE_OCC_EN
            chk("rst_occ", 32'(occ), 32'h0);
`endif
        end
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            chk("post_rst_vld", 32'(Q_vld), 32'(i == DEPTH));
            chk_model("post_rst");
        end
        chk("post_rst_Q", 32'(Q), 32'hFF);

        // Drain with invalid words: data bits are shifted, not zeroed.
        drive(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < DEPTH; i++) tick();
        chk("drain_Q_vld", 32'(Q_vld), 32'h0);
        chk("drain_Q_data_kept", 32'(Q), 32'hFF);

        // Latency: single valid word emerges after DEPTH enabled edges, one cycle only.
        drive(1'b1, 8'hA5, 1'b1);
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            drive(1'b1, 8'h00, 1'b0);
            chk("lat_vld", 32'(Q_vld), 32'(i == DEPTH));
            chk_model("lat");
        end
        chk("lat_Q", 32'(Q), 32'hA5);
        tick();
        chk("lat_vld_one_cycle", 32'(Q_vld), 32'h0);

        // Stall mid-stream.
        drive(1'b1, 8'h11, 1'b1); tick();
        drive(1'b1, 8'h22, 1'b1); tick();
        drive(1'b1, 8'h33, 1'b1); tick();
        drive(1'b0, 8'hEE, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_Q", 32'(Q), 32'h00);
            chk("stall_Q_vld", 32'(Q_vld), 32'h0);
        end
        drive(1'b1, 8'h00, 1'b0);
        tick(); chk("stall_out0", 32'({Q_vld, Q}), 32'h111);
        tick(); chk("stall_out1", 32'({Q_vld, Q}), 32'h122);
        tick(); chk("stall_out2", 32'({Q_vld, Q}), 32'h133);
        tick(); chk("stall_out3_vld", 32'(Q_vld), 32'h0);

        // Flush wins over enable; the word presented with flush is dropped.
        drive(1'b1, 8'h44, 1'b1); tick();
        drive(1'b1, 8'h55, 1'b1); tick();
        drive(1'b1, 8'h66, 1'b1); tick();
        flush = 1'b1;
        drive(1'b1, 8'h77, 1'b1);
        tick();
        flush = 1'b0;
        chk("flush_Q", 32'(Q), 32'h0);
        chk("flush_Q_vld", 32'(Q_vld), 32'h0);
`ifdef DFF_E_PIPE_OCC_EN
        chk("flush_occ", 32'(occ), 32'h0);
`endif
        drive(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            tick();
            chk("flush_no77", 32'({Q_vld, Q}), 32'h000);
        end

        // Occupancy fill and alternating drain.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'(8'h81 + i), 1'b1);
            tick();
        end
        chk_model("fill");
`ifdef DFF_E_PIPE_OCC_EN
        chk("fill_occ", 32'(occ), 32'd4);
`endif
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'hC0 + i), (i % 2) == 0);
            tick();
            chk_model("alt");
`ifdef DFF_E_PIPE_OCC_EN
            chk("alt_occ", 32'(occ), 32'(occ_exp[i]));
`endif
        end

        // Random soak against the queue model.
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            tick();
            chk_model("soak");
        end

        // Mid-stream reset discards in-flight words.
        drive(1'b1, 8'h5A, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst", 32'({Q_vld, Q}), 32'h000);
        chk_model("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dff_e_pipe.md
# dff_e_pipe

Parametrised enabled register pipeline: WIDTH-bit data plus a per-stage valid bit through DEPTH enabled flip-flop stages. It advances only while enable E is high and holds otherwise. Synchronous flush invalidates all in-flight data. It replaces single enabled D flip-flops wherever the design needs an enabled, stallable delay of N cycles with valid tracking.

## Interface
Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of stages, i.e. the latency in enabled cycles (>=1)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset: synchronous, active-high
- E  input  1  enable; high = pipeline advances one stage this edge
- flush  input  1  synchronous flush; invalidates and zeroes all stages
- D  input  WIDTH  data into stage 0
- D_vld  input  1  valid qualifier for D
- Q  output  WIDTH  data of the last stage (DEPTH-1), registered
- Q_vld  output  1  valid of the last stage, registered
- occ  output  $clog2(DEPTH+1)  number of valid stages (only with DFF_E_PIPE_OCC_EN)

## Operation
- Each stage k holds data[k] and vld[k]. Q = data[DEPTH-1], Q_vld = vld[DEPTH-1]. No combinational path from inputs to outputs.
- Priority at each rising edge: rst > flush > E > hold.
- rst: every data[k] = 0 and every vld[k] = 0. Result: Q = 0, Q_vld = 0, occ = 0.
- flush (rst low): same clearing as rst. D and D_vld presented on that edge are dropped, even when E = 1.
- E = 1 (no rst or flush): data[0] <= D, vld[0] <= D_vld, and data[k] <= data[k-1], vld[k] <= vld[k-1] for k >= 1. The word in the last stage leaves the pipeline.
- E = 0: all stages hold. D and D_vld are ignored.
- Invalid words (D_vld = 0) still shift their data bits. The data bits are not zeroed; consumers qualify Q only with Q_vld.
- DEPTH = 1 degenerates to a single enabled register with valid. This is the direct replacement for the single enabled D flip-flop.

## Timing
- Latency: a word accepted at edge n with E = 1 appears on Q/Q_vld after exactly DEPTH edges with E = 1. Edges with E = 0 in between add no advancement.
- Reset is synchronous. Outputs change only at a clock edge where rst = 1. rst asserted mid-stream discards all in-flight words on that edge.
- Back-to-back valid words with E held high produce Q_vld high on consecutive cycles, giving full throughput.
- Outputs are stable between edges. They are glitch-free and registered.

## Configuration
- DFF_E_PIPE_OCC_EN defined:
  - occ port exists and is a registered counter.
  - On rst or flush: occ <= 0.
  - On E = 1: occ <= occ + D_vld - vld[DEPTH-1].
  - On E = 0: hold.
  - Range is 0..DEPTH. It never wraps, and an invariant check enforces this in simulation.
- DFF_E_PIPE_OCC_EN not defined:
  - occ port and counter are absent.
  - Behaviour of Q/Q_vld is identical.

## Structure
- Package dff_e_pkg holds:
  - a function returning the occupancy width $clog2(DEPTH+1), with a minimum of 1;
  - the reset value constant for data (all zeros).
- Sub-module dff_e_stage: one enabled register stage carrying WIDTH data plus valid, with rst/flush/E priority.
- dff_e_pipe instantiates DEPTH copies of dff_e_stage in a generate loop.
- The top level adds the optional occupancy counter.

## Test plan
- **Reset:** drive rst = 1 for 2 cycles with D = 8'hFF, D_vld = 1, E = 1 -> Q = 0, Q_vld = 0, occ = 0 throughout; first valid appears DEPTH edges after rst falls.
- **Latency:** DEPTH = 4, E = 1, inject D = 8'hA5 with D_vld = 1 for one cycle, then D_vld = 0 -> Q = 8'hA5 with Q_vld = 1 exactly 4 edges later, for one cycle only.
- **Stall:** inject 8'h11, 8'h22, 8'h33 back-to-back, then hold E = 0 for 5 cycles mid-stream -> outputs frozen during the stall; words emerge in order 11, 22, 33 after 4 total enabled edges each.
- **Flush vs enable:** with 3 valid words in flight, assert flush = 1 and E = 1 together with D = 8'h77, D_vld = 1 -> next cycle all stages invalid, Q = 0, occ = 0; 8'h77 never appears.
- **Occupancy** (macro on): fill with 4 valid words at E = 1 -> occ = 4. Keep shifting with D_vld alternating 1/0 -> occ steps down to 2 and stays there. It never exceeds 4 and never underflows.
- **Random soak:** 1000 cycles of random D, D_vld and E with rst low, checked against a queue-based reference model -> Q and Q_vld match every cycle.
